// File: rtl/dsp_host_if_pkg.sv
// Shared definitions for the DSP host command interface: opcodes, FSM states
// and shadow word-select indices.
package dsp_host_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [7:0] OP_SET_TX    = 8'h01;
  localparam logic [7:0] OP_SET_RX    = 8'h02;
  localparam logic [7:0] OP_SET_BER   = 8'h03;
  localparam logic [7:0] OP_SET_PHASE = 8'h04;
  localparam logic [7:0] OP_SNAPSHOT  = 8'h05;
  localparam logic [7:0] OP_READ      = 8'h06;
  localparam logic [7:0] OP_STATUS    = 8'h07;

  localparam logic [2:0] SEL_ERR_R_LO = 3'd0;
  localparam logic [2:0] SEL_ERR_R_HI = 3'd1;
  localparam logic [2:0] SEL_ERR_I_LO = 3'd2;
  localparam logic [2:0] SEL_ERR_I_HI = 3'd3;
  localparam logic [2:0] SEL_BIT_R_LO = 3'd4;
  localparam logic [2:0] SEL_BIT_R_HI = 3'd5;
  localparam logic [2:0] SEL_BIT_I_LO = 3'd6;
  localparam logic [2:0] SEL_BIT_I_HI = 3'd7;

endpackage

// File: rtl/dsp_host_if_cmd_sync.sv
// Registers the host command word and flags a qualified 0->1 strobe edge.
module dsp_host_if_cmd_sync (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_cmd,
  output logic        o_stb,
  output logic        o_start,
  output logic [7:0]  o_op,
  output logic [2:0]  o_arg
);

  logic       r_stb;
  logic       r_stb_d;
  logic       r_armed;
  logic [7:0] r_op;
  logic [2:0] r_arg;
  logic       w_unused_arg;

  assign w_unused_arg = ^i_cmd[22:3];

  // r_armed stays low until strobe is seen low after reset, so a strobe held
  // high across reset release cannot look like a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stb   <= 1'b0;
      r_stb_d <= 1'b0;
      r_armed <= 1'b0;
      r_op    <= '0;
      r_arg   <= '0;
    end else begin
      r_stb   <= i_cmd[23];
      r_stb_d <= r_stb;
      r_armed <= r_armed | ~i_cmd[23];
      r_op    <= i_cmd[31:24];
      r_arg   <= i_cmd[2:0];
    end
  end

  assign o_stb   = r_stb;
  assign o_start = r_stb & ~r_stb_d & r_armed;
  assign o_op    = r_op;
  assign o_arg   = r_arg;

endmodule

// File: rtl/dsp_host_if.sv
// Host command interface for the DSP: enables, sampling phase and a snapshot
// of the live BER counters readable as 32-bit words, with an ack handshake.
module dsp_host_if
  import dsp_host_if_pkg::*;
#(
  parameter int unsigned REG_COUNT_LEN = 64,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              i_cmd,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_ack,
  output logic                     o_enable_tx,
  output logic                     o_enable_rx,
  output logic                     o_enable_ber,
  output logic [1:0]               o_phase,
  input  logic [REG_COUNT_LEN-1:0] i_error_count_r,
  input  logic [REG_COUNT_LEN-1:0] i_error_count_i,
  input  logic [REG_COUNT_LEN-1:0] i_bit_count_r,
  input  logic [REG_COUNT_LEN-1:0] i_bit_count_i
);

  logic                     w_stb;
  logic                     w_start;
  logic [7:0]               w_op;
  logic [2:0]               w_arg;
  logic [REG_COUNT_LEN-1:0] w_shadow;
  logic [DATA_W-1:0]        w_read;

  state_t                   r_state;
  logic [7:0]               r_op;
  logic [2:0]               r_arg;
  logic                     r_snap_valid;
  logic [REG_COUNT_LEN-1:0] r_sh_err_r;
  logic [REG_COUNT_LEN-1:0] r_sh_err_i;
  logic [REG_COUNT_LEN-1:0] r_sh_bit_r;
  logic [REG_COUNT_LEN-1:0] r_sh_bit_i;

  dsp_host_if_cmd_sync u_cmd_sync (
    .clk     (clk),
    .rst     (rst),
    .i_cmd   (i_cmd),
    .o_stb   (w_stb),
    .o_start (w_start),
    .o_op    (w_op),
    .o_arg   (w_arg)
  );

  always_comb begin
    w_shadow = r_sh_err_r;
    case (r_arg)
      SEL_ERR_R_LO, SEL_ERR_R_HI: w_shadow = r_sh_err_r;
      SEL_ERR_I_LO, SEL_ERR_I_HI: w_shadow = r_sh_err_i;
      SEL_BIT_R_LO, SEL_BIT_R_HI: w_shadow = r_sh_bit_r;
      SEL_BIT_I_LO, SEL_BIT_I_HI: w_shadow = r_sh_bit_i;
      default:                    w_shadow = r_sh_err_r;
    endcase
    w_read = r_arg[0] ? DATA_W'(w_shadow >> DATA_W) : DATA_W'(w_shadow);
  end

  // Opcode/argument are latched on acceptance so later changes on i_cmd
  // cannot alter a command already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_arg        <= '0;
      r_snap_valid <= 1'b0;
      r_sh_err_r   <= '0;
      r_sh_err_i   <= '0;
      r_sh_bit_r   <= '0;
      r_sh_bit_i   <= '0;
      o_data       <= '0;
      o_ack        <= 1'b0;
      o_enable_tx  <= 1'b0;
      o_enable_rx  <= 1'b0;
      o_enable_ber <= 1'b0;
      o_phase      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op    <= w_op;
            r_arg   <= w_arg;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_ACK;
          o_ack   <= 1'b1;
          o_data  <= '0;
          case (r_op)
            OP_SET_TX:    o_enable_tx  <= r_arg[0];
            OP_SET_RX:    o_enable_rx  <= r_arg[0];
            OP_SET_BER:   o_enable_ber <= r_arg[0];
            OP_SET_PHASE: o_phase      <= r_arg[1:0];
            OP_SNAPSHOT: begin
              r_sh_err_r   <= i_error_count_r;
              r_sh_err_i   <= i_error_count_i;
              r_sh_bit_r   <= i_bit_count_r;
              r_sh_bit_i   <= i_bit_count_i;
              r_snap_valid <= 1'b1;
            end
            OP_READ:   o_data <= w_read;
            OP_STATUS: o_data <= DATA_W'({r_snap_valid, o_enable_ber, o_enable_rx,
                                          o_enable_tx, o_phase});
            default:   o_data <= '1;
          endcase
        end
        ST_ACK: begin
          if (!w_stb) begin
            r_state <= ST_IDLE;
            o_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_host_if.sv
// Self-checking bench for dsp_host_if: transaction-level model checked every
// cycle, plus literal expectations for the key responses.
module tb_dsp_host_if;
  import dsp_host_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_cmd = '0;
  logic [31:0] o_data;
  logic        o_ack, o_enable_tx, o_enable_rx, o_enable_ber;
  logic [1:0]  o_phase;
  logic [63:0] cnt_er = '0, cnt_ei = '0, cnt_br = '0, cnt_bi = '0;

  dsp_host_if #(.REG_COUNT_LEN(64), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cmd           (i_cmd),
    .o_data          (o_data),
    .o_ack           (o_ack),
    .o_enable_tx     (o_enable_tx),
    .o_enable_rx     (o_enable_rx),
    .o_enable_ber    (o_enable_ber),
    .o_phase         (o_phase),
    .i_error_count_r (cnt_er),
    .i_error_count_i (cnt_ei),
    .i_bit_count_r   (cnt_br),
    .i_bit_count_i   (cnt_bi)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;

  logic        m_ack, m_tx, m_rx, m_ber, m_snap;
  logic [1:0]  m_phase;
  logic [31:0] m_data;
  logic [63:0] m_sh [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ack = 0; m_tx = 0; m_rx = 0; m_ber = 0; m_snap = 0;
    m_phase = '0; m_data = '0;
    for (int i = 0; i < 4; i++) m_sh[i] = '0;
  endtask

  task automatic model_exec(input logic [7:0] op, input logic [22:0] arg);
    logic [63:0] w;
    m_ack  = 1'b1;
    m_data = '0;
    case (op)
      OP_SET_TX:    m_tx = arg[0];
      OP_SET_RX:    m_rx = arg[0];
      OP_SET_BER:   m_ber = arg[0];
      OP_SET_PHASE: m_phase = arg[1:0];
      OP_SNAPSHOT: begin
        m_sh[0] = cnt_er; m_sh[1] = cnt_ei; m_sh[2] = cnt_br; m_sh[3] = cnt_bi;
        m_snap = 1'b1;
      end
      OP_READ: begin
        w = m_sh[arg[2:1]];
        m_data = arg[0] ? w[63:32] : w[31:0];
      end
      OP_STATUS: m_data = {26'b0, m_snap, m_ber, m_rx, m_tx, m_phase};
      default:   m_data = 32'hFFFF_FFFF;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ack",   32'(o_ack),        32'(m_ack));
      chk("cyc_data",  o_data,            m_data);
      chk("cyc_tx",    32'(o_enable_tx),  32'(m_tx));
      chk("cyc_rx",    32'(o_enable_rx),  32'(m_rx));
      chk("cyc_ber",   32'(o_enable_ber), 32'(m_ber));
      chk("cyc_phase", 32'(o_phase),      32'(m_phase));
    end
  end

  // Strobe rises before edge N; ack must be low after N+1 and high after N+2.
  // With hold>0 the opcode/argument are scrambled while strobe stays high.
  task automatic run_cmd(input logic [7:0] op, input logic [22:0] arg,
                         input int unsigned hold, input logic [7:0] alt_op);
    @(negedge clk); i_cmd = {op, 1'b1, arg};
    @(posedge clk);
    if (hold != 0) begin
      @(negedge clk); i_cmd = {alt_op, 1'b1, ~arg};
    end
    @(posedge clk); #1 chk("lat_n1", 32'(o_ack), 32'd0);
    @(posedge clk); #1 model_exec(op, arg);
    chk("lat_n2", 32'(o_ack), 32'd1);
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk); i_cmd = {(k[0] ? op : alt_op), 1'b1, (k[0] ? arg : ~arg)};
    end
    @(negedge clk); i_cmd[23] = 1'b0;
    @(posedge clk); #1 chk("ack_hold", 32'(o_ack), 32'd1);
    @(posedge clk); #1 m_ack = 1'b0;
    chk("ack_drop", 32'(o_ack), 32'd0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ack",   32'(o_ack),   32'd0);
    chk("rst_data",  o_data,       32'd0);
    chk("rst_tx",    32'(o_enable_tx), 32'd0);
    chk("rst_phase", 32'(o_phase), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(OP_SET_TX, 23'd1, 0, 8'h00);
    chk("settx_en",   32'(o_enable_tx), 32'd1);
    chk("settx_data", o_data, 32'd0);

    run_cmd(OP_SET_TX, 23'd0, 0, 8'h00);
    run_cmd(OP_SET_PHASE, 23'd2, 0, 8'h00);
    run_cmd(OP_STATUS, 23'd0, 0, 8'h00);
    chk("status_ph2", o_data, 32'h0000_0002);

    run_cmd(OP_SET_RX, 23'd1, 0, 8'h00);
    run_cmd(OP_SET_BER, 23'd1, 0, 8'h00);
    run_cmd(OP_STATUS, 23'd0, 0, 8'h00);
    chk("status_en", o_data, 32'h0000_001A);

    run_cmd(OP_READ, 23'd4, 0, 8'h00);
    chk("read_presnap", o_data, 32'd0);

    run_cmd(8'h3C, 23'h12345, 0, 8'h00);
    chk("bad_op_data", o_data, 32'hFFFF_FFFF);
    chk("bad_op_rx", 32'(o_enable_rx), 32'd1);

    cnt_er = 64'h0000_0001_0000_0005;
    cnt_ei = 64'h1234_5678_9ABC_DEF0;
    cnt_br = 64'h0000_00AA_0000_00BB;
    cnt_bi = 64'hFFFF_FFFF_FFFF_FFFF;
    run_cmd(OP_SNAPSHOT, 23'd0, 0, 8'h00);
    chk("snap_data", o_data, 32'd0);
    cnt_er = 64'h0000_0000_0000_0000;
    cnt_ei = 64'hDEAD_BEEF_0000_1111;
    cnt_br = 64'h5555_5555_5555_5555;
    cnt_bi = 64'h0000_0000_0000_0001;
    run_cmd(OP_READ, 23'd0, 0, 8'h00);
    chk("read_sel0", o_data, 32'h0000_0005);
    run_cmd(OP_READ, 23'd1, 0, 8'h00);
    chk("read_sel1", o_data, 32'h0000_0001);
    run_cmd(OP_READ, 23'd7, 0, 8'h00);
    chk("read_sel7", o_data, 32'hFFFF_FFFF);
    run_cmd(OP_READ, 23'd2, 0, 8'h00);
    run_cmd(OP_READ, 23'd5, 0, 8'h00);
    chk("read_sel5", o_data, 32'h0000_00AA);
    run_cmd(OP_STATUS, 23'd0, 0, 8'h00);
    chk("status_snap", o_data, 32'h0000_003A);

    run_cmd(OP_SET_PHASE, 23'd1, 4, OP_SET_RX);
    chk("hold_phase", 32'(o_phase), 32'd1);
    chk("hold_rx",    32'(o_enable_rx), 32'd1);

    @(negedge clk); i_cmd = {OP_SET_TX, 1'b1, 23'd1};
    @(posedge clk); @(posedge clk);
    @(posedge clk); #1 model_exec(OP_SET_TX, 23'd1);
    chk("rst_mid_ack", 32'(o_ack), 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("abort_ack",   32'(o_ack),        32'd0);
    chk("abort_data",  o_data,            32'd0);
    chk("abort_tx",    32'(o_enable_tx),  32'd0);
    chk("abort_rx",    32'(o_enable_rx),  32'd0);
    chk("abort_ber",   32'(o_enable_ber), 32'd0);
    chk("abort_phase", 32'(o_phase),      32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_retrig_ack", 32'(o_ack), 32'd0);
    chk("no_retrig_tx",  32'(o_enable_tx), 32'd0);
    i_cmd[23] = 1'b0;
    repeat (2) @(negedge clk);

    run_cmd(OP_STATUS, 23'd0, 0, 8'h00);
    chk("status_post_rst", o_data, 32'd0);
    run_cmd(OP_READ, 23'd7, 0, 8'h00);
    chk("read_post_rst", o_data, 32'd0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_host_if.md
DSP_HOST_IF -- requirements
Module: dsp_host_if

Interface
REQ-001 SHALL have parameter REG_COUNT_LEN, default 64: width of each BER counter input.
REQ-002 SHALL have parameter DATA_W, default 32: width of host command/data words.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_cmd, input, 32: host command word; [31:24] opcode, [23] strobe, [22:0] argument.
REQ-006 SHALL have port o_data, output, 32: response word to host.
REQ-007 SHALL have port o_ack, output, 1: command-complete handshake flag.
REQ-008 SHALL have ports o_enable_tx, o_enable_rx, o_enable_ber, output, 1 each: DSP enables.
REQ-009 SHALL have port o_phase, output, 2: receiver sampling phase.
REQ-010 SHALL have ports i_error_count_r, i_error_count_i, i_bit_count_r, i_bit_count_i, input, REG_COUNT_LEN each: live BER counters from the DSP.

Function
REQ-011 SHALL register i_cmd every cycle; a command is accepted only on a 0->1 transition of registered strobe while FSM is IDLE.
REQ-012 SHALL implement FSM states IDLE, EXEC, ACK; IDLE->EXEC on accepted strobe edge; EXEC->ACK unconditionally; ACK->IDLE when registered strobe is 0.
REQ-013 SHALL assert o_ack only in ACK; i_cmd strobe rising at clock edge N yields o_ack high after edge N+2.
REQ-014 SHALL ignore opcode/argument changes and further strobe edges while in EXEC or ACK.
REQ-015 Opcode 0x01 SET_TX SHALL load o_enable_tx from arg[0]; 0x02 SET_RX loads o_enable_rx; 0x03 SET_BER loads o_enable_ber; 0x04 SET_PHASE loads o_phase from arg[1:0]; all take effect at EXEC->ACK edge.
REQ-016 Opcode 0x05 SNAPSHOT SHALL copy all four counter inputs into shadow registers on the same clock edge and set snap_valid.
REQ-017 Opcode 0x06 READ SHALL select shadow word by arg[2:0]: 0/1 error_r low/high, 2/3 error_i low/high, 4/5 bit_r low/high, 6/7 bit_i low/high; o_data holds it until next command completes.
REQ-018 Opcode 0x07 STATUS SHALL return o_data = {26'b0, snap_valid, o_enable_ber, o_enable_rx, o_enable_tx, o_phase}.
REQ-019 Any other opcode SHALL leave state unchanged, return o_data = 32'hFFFF_FFFF, and still complete the ACK handshake.
REQ-020 READ before any SNAPSHOT SHALL return 0.
REQ-021 Shadow registers SHALL change only on SNAPSHOT; live counter wrap-around is passed through unmodified.
REQ-022 Write opcodes (0x01-0x05) SHALL return o_data = 0.
REQ-023 If strobe is still 1 when entering IDLE it SHALL NOT re-trigger; a new 0->1 edge is required.

Reset
REQ-024 On rst low SHALL asynchronously clear: FSM to IDLE, o_ack, o_data, all enables, o_phase, shadow registers, snap_valid, registered i_cmd.
REQ-025 Reset mid-handshake SHALL abort the command; a strobe held high across reset release SHALL NOT trigger a command.

Structure
REQ-026 Opcode values, FSM state encodings and word-select indices SHALL live in a shared package/header used by the DSP top and testbench.
REQ-027 A single sub-module cmd_sync (strobe register + edge detect) is permitted; the rest is flat.

Verification
REQ-028 Reset, then SET_TX arg=1 strobe -> o_ack high 2 cycles after strobe edge, o_enable_tx=1, o_data=0; drop strobe -> o_ack low next cycle.
REQ-029 SET_PHASE arg=2'b10, then STATUS -> o_data=32'h0000_0002 with no enables set.
REQ-030 Counters error_r=64'h0000_0001_0000_0005, bit_i=64'hFFFF_FFFF_FFFF_FFFF; SNAPSHOT, change counters, READ sel 0,1,7 -> 5, 1, FFFF_FFFF.
REQ-031 READ sel 4 before any SNAPSHOT -> o_data=0; opcode 0x3C -> o_data=FFFF_FFFF, o_ack asserted, enables unchanged.
REQ-032 Hold strobe high through ACK and toggle opcode -> exactly one command executed; assert rst during ACK -> o_ack and all outputs 0, no command on rst release with strobe high.
